div4_seq_ctrl: RTL and testbench

- Sequential 4-bit unsigned restoring divider controller.
- Time-multiplexes one existing AddSub4 instance (ports a, b, sel, s, cout) in subtract mode, one quotient bit per clock.
- Sits beside the AddSub4 datapath in the lab arithmetic set; accepts a start pulse and returns quotient/remainder with busy/done status.

---
 rtl/div4_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_div4_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div4_seq_ctrl.sv
// div4_seq_ctrl: sequential 4-bit unsigned restoring divider controller.
// Produces one quotient bit per clock using a subtract-mode AddSub4 datapath
// (a + ~b + 1, cout=1 means no borrow). Four iterations per operation.
// Optional feature macro: DIV_ZERO_CHK_EN. When it is defined, a divide by
// zero finishes in one cycle with err=1. When it is undefined, err is held at 0.
module div4_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] dreg_q, dreg_d;
  logic [1:0] cnt_q, cnt_d;
  logic       busy_d, done_d, err_d;
  logic [3:0] q_d, r_d;

  // AddSub4 hookup in subtract mode: a={R[2:0],Q[3]}, b=Dreg, sel=1
  logic [3:0] sub_a, sub_b, sub_s;
  logic       sub_sel, sub_cout;
  logic       ge;
  logic [3:0] rem_next, quo_next;

  assign sub_a   = {rem_q[2:0], quo_q[3]};
  assign sub_b   = dreg_q;
  assign sub_sel = 1'b1;
  assign {sub_cout, sub_s} = {1'b0, sub_a} + {1'b0, sub_b ^ {4{sub_sel}}} + {4'b0, sub_sel};

  // R[3] set means the 5-bit shifted remainder is >= 16, so it always exceeds D
  assign ge       = rem_q[3] | sub_cout;
  assign rem_next = ge ? sub_s : sub_a;
  assign quo_next = {quo_q[2:0], ge};

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= 4'h0;
      quo_q   <= 4'h0;
      dreg_q  <= 4'h0;
      cnt_q   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      q       <= 4'h0;
      r       <= 4'h0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dreg_q  <= dreg_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      q       <= q_d;
      r       <= r_d;
    end
  end

  // Next-state: accept in idle, iterate in run, publish result on last step
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dreg_d  = dreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef DIV_ZERO_CHK_EN
    err_d   = err;
`else
    err_d   = 1'b0;
`endif
    q_d     = q;
    r_d     = r;

    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef DIV_ZERO_CHK_EN
          if (divisor == 4'h0) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            q_d    = 4'hF;
            r_d    = dividend;
          end else begin
            dreg_d  = divisor;
            quo_d   = dividend;
            rem_d   = 4'h0;
            cnt_d   = 2'd0;
            busy_d  = 1'b1;
            state_d = StRun;
          end
`else
          dreg_d  = divisor;
          quo_d   = dividend;
          rem_d   = 4'h0;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = StRun;
`endif
        end
      end
      StRun: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          q_d     = quo_next;
          r_d     = rem_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// Self-checking bench for div4_seq_ctrl: directed cases plus random operands
// checked against an arithmetic reference (N/D, N%D, divide-by-zero rule).
module tb_div4_seq_ctrl;

`ifdef DIV_ZERO_CHK_EN
  localparam bit ZChk = 1'b1;
`else
  localparam bit ZChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, err;
  logic [3:0] q, r;

  div4_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int last_q = 0;
  int last_r = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_q(input int n, input int d);
    return (d == 0) ? 15 : n / d;
  endfunction

  function automatic int ref_r(input int n, input int d);
    return (d == 0) ? n : n % d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; poke fires a competing start while busy
  task automatic run_op(input int n, input int d, input bit poke);
    int cyc;
    int exp_lat;
    dividend = 4'(n);
    divisor  = 4'(d);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 4'($urandom_range(0, 15));
    divisor  = 4'($urandom_range(0, 15));
    exp_lat  = (ZChk && d == 0) ? 0 : 4;
    cyc      = 0;
    while (!done && cyc < 10) begin
      check("busy_run", busy, 1);
      check("q_hold", q, last_q);
      check("r_hold", r, last_r);
      if (poke && cyc == 1) begin
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("q", q, ref_q(n, d));
    check("r", r, ref_r(n, d));
    check("err", err, (ZChk && d == 0) ? 1 : 0);
    last_q = ref_q(n, d);
    last_r = ref_r(n, d);
    tick();
    check("done_pulse", done, 0);
  endtask

  int bn[3] = '{13, 15, 9};
  int bd[3] = '{3, 2, 4};

  initial begin
    int cyc;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'h0;
    divisor  = 4'h0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    run_op(13, 3, 1'b0);
    run_op(15, 1, 1'b0);
    run_op(7, 9, 1'b0);
    run_op(8, 8, 1'b0);
    run_op(15, 9, 1'b0);
    run_op(0, 5, 1'b0);
    run_op(13, 3, 1'b1);

    // start held high: back-to-back operations every 5 cycles
    dividend = 4'(bn[0]);
    divisor  = 4'(bd[0]);
    start    = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      while (!done && cyc < 10) begin
        tick();
        cyc++;
      end
      check("b2b_latency", cyc, 4);
      check("b2b_q", q, ref_q(bn[i], bd[i]));
      check("b2b_r", r, ref_r(bn[i], bd[i]));
      if (i < 2) begin
        dividend = 4'(bn[i+1]);
        divisor  = 4'(bd[i+1]);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("b2b_end_done", done, 0);
    check("b2b_end_busy", busy, 0);
    last_q = ref_q(bn[2], bd[2]);
    last_r = ref_r(bn[2], bd[2]);

    // Reset during the second RUN cycle aborts with no done
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_err", err, 0);
    last_q = 0;
    last_r = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", done, 0);
    end
    rst = 1'b0;
    tick();
    run_op(12, 5, 1'b0);

    run_op(11, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
